// File: rtl/vdp_pkg.sv
// vdp_pkg: shared status bit positions, register bit positions and VRAM FSM states for the vdp host port.
package vdp_pkg;
  localparam int STAT_F      = 7;
  localparam int STAT_C      = 6;
  localparam int STAT_5S     = 5;
  localparam int REG1_IE_BIT = 5;
  typedef enum logic {IDLE, BUSY} vram_state_e;
endpackage

// File: rtl/vdp_cpu_port_if.sv
// vdp_cpu_port_if: VRAM req/ack bus between the host port (master) and VRAM arbitration (slave).
interface vdp_cpu_port_if #(parameter int ADDR_W = 14);
  logic              req, we, ack;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata, rdata;
  modport master(output req, we, addr, wdata, input ack, rdata);
  modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/vdp_vram_req.sv
// vdp_vram_req: single-slot VRAM request holder; req/we/addr/wdata stay stable from issue until ack.
module vdp_vram_req
  import vdp_pkg::*;
#(parameter int ADDR_W = 14) (
  input  logic              pxclk,
  input  logic              reset_n,
  input  logic              issue_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  input  logic              ack_i,
  input  logic [7:0]        rdata_i,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        wdata_o,
  output logic              busy_o,
  output logic              rd_valid_o,
  output logic [7:0]        rd_data_o
);
  vram_state_e       state_q, state_d;
  logic              we_q, we_d, ld;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  always_comb begin
    ld      = state_q == IDLE && issue_i;
    state_d = ld ? BUSY : (state_q == BUSY && ack_i) ? IDLE : state_q;
    we_d    = ld ? we_i : we_q;
    addr_d  = ld ? addr_i : addr_q;
    wdata_d = ld ? wdata_i : wdata_q;
  end
  always_ff @(posedge pxclk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  assign req_o      = state_q == BUSY;
  assign busy_o     = state_q == BUSY;
  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign rd_valid_o = state_q == BUSY && ack_i && !we_q;
  assign rd_data_o  = rdata_i;
endmodule

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: two-byte control-port protocol, VRAM address auto-increment, read-ahead buffer, status/IRQ.
// Collision and fifth-sprite status bits are built only when VDP_COLLISION_EN is defined.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int NUM_REGS = 8
) (
  input  logic                  pxclk,
  input  logic                  reset_n,
  input  logic                  wr_tick,
  input  logic                  rd_tick,
  input  logic                  mode,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  irq,
  input  logic                  frame_tick,
  input  logic                  coll_tick,
  input  logic                  fifth_tick,
  input  logic [4:0]            fifth_num,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  ovr,
  vdp_cpu_port_if.master        vram
);
  localparam int IDX_W = $clog2(NUM_REGS);
  logic [7:0]        low_q, low_d, buf_q, buf_d, rd_data;
  logic              flag_q, flag_d, f_q, f_d, ovr_q, ovr_d;
  logic [ADDR_W-1:0] addr_q, addr_d, new_addr, iss_addr;
  logic [7:0]        regs_q [NUM_REGS];
  logic [7:0]        regs_d [NUM_REGS];
  logic [6:0]        stat_lo;
  logic              ctl_lo, ctl_hi, set_addr, prefetch, data_acc, stat_rd, want, issue, busy, rd_valid;
  assign ctl_lo   = wr_tick & mode & ~flag_q;
  assign ctl_hi   = wr_tick & mode & flag_q;
  assign set_addr = ctl_hi & ~din[7];
  assign prefetch = set_addr & ~din[6];
  assign data_acc = ~mode & (wr_tick | rd_tick);
  assign stat_rd  = rd_tick & ~wr_tick & mode;
  assign want     = data_acc | prefetch;
  assign issue    = want & ~busy;
  assign new_addr = {din[ADDR_W-9:0], low_q};
  assign iss_addr = set_addr ? new_addr : addr_q;
  // Address advances when an access is accepted; a dropped access leaves it alone.
  always_comb begin
    low_d  = ctl_lo ? din : low_q;
    flag_d = ctl_lo | (flag_q & ~(ctl_hi | data_acc | stat_rd));
    addr_d = issue ? iss_addr + ADDR_W'(1) : set_addr ? new_addr : addr_q;
    buf_d  = rd_valid ? rd_data : (issue & ~mode & wr_tick) ? din : buf_q;
    f_d    = frame_tick | (f_q & ~stat_rd);
    ovr_d  = ovr_q | (want & busy);
    regs_d = regs_q;
    if (ctl_hi & din[7]) regs_d[din[IDX_W-1:0]] = low_q;
  end
  always_ff @(posedge pxclk or negedge reset_n)
    if (!reset_n) begin
      low_q  <= '0;
      flag_q <= 1'b0;
      addr_q <= '0;
      buf_q  <= '0;
      f_q    <= 1'b0;
      ovr_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      low_q  <= low_d;
      flag_q <= flag_d;
      addr_q <= addr_d;
      buf_q  <= buf_d;
      f_q    <= f_d;
      ovr_q  <= ovr_d;
      regs_q <= regs_d;
    end
`ifdef VDP_COLLISION_EN
  logic       c_q, c_d, s5_q, s5_d, ld5;
  logic [4:0] num_q, num_d;
  // A new fifth-sprite event is latched only while 5S is clear, or when the same-cycle read frees it.
  always_comb begin
    ld5     = fifth_tick & (~s5_q | stat_rd);
    c_d     = coll_tick | (c_q & ~stat_rd);
    s5_d    = ld5 | (s5_q & ~stat_rd);
    num_d   = ld5 ? fifth_num : stat_rd ? 5'd0 : num_q;
    stat_lo = '0;
    stat_lo[STAT_C]  = c_q;
    stat_lo[STAT_5S] = s5_q;
    stat_lo[4:0]     = num_q;
  end
  always_ff @(posedge pxclk or negedge reset_n)
    if (!reset_n) begin
      c_q   <= 1'b0;
      s5_q  <= 1'b0;
      num_q <= '0;
    end else begin
      c_q   <= c_d;
      s5_q  <= s5_d;
      num_q <= num_d;
    end
`else
  logic unused_coll;
  assign unused_coll = ^{coll_tick, fifth_tick, fifth_num};
  assign stat_lo = '0;
`endif
  vdp_vram_req #(.ADDR_W(ADDR_W)) u_req (
    .pxclk      (pxclk),
    .reset_n    (reset_n),
    .issue_i    (issue),
    .we_i       (~mode & wr_tick),
    .addr_i     (iss_addr),
    .wdata_i    (din),
    .ack_i      (vram.ack),
    .rdata_i    (vram.rdata),
    .req_o      (vram.req),
    .we_o       (vram.we),
    .addr_o     (vram.addr),
    .wdata_o    (vram.wdata),
    .busy_o     (busy),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data)
  );
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*8+:8] = regs_q[g];
  end
  assign dout = mode ? {f_q, stat_lo} : buf_q;
  assign irq  = f_q & regs_q[1][REG1_IE_BIT];
  assign ovr  = ovr_q;
endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb_vdp_cpu_port: directed scoreboard bench for vdp_cpu_port; expected VRAM ops and host read bytes are queued, monitors compare.
module tb_vdp_cpu_port;
  logic clk = 0, rst_n = 0, wr_tick = 0, rd_tick = 0, mode = 0;
  logic frame_tick = 0, coll_tick = 0, fifth_tick = 0, hold_ack = 0;
  logic [7:0] din = 0;
  logic [4:0] fifth_num = 0;
  logic [7:0] dout;
  logic irq, ovr;
  logic [63:0] regs;
  int checks = 0, failures = 0;
  typedef struct packed {logic we; logic [13:0] addr; logic [7:0] wdata;} vop_t;
  vop_t vq[$];
  vop_t e;
  logic [7:0] dq[$];
`ifdef VDP_COLLISION_EN
  localparam logic [7:0] EXP_5S = 8'h33, EXP_C = 8'h40;
`else
  localparam logic [7:0] EXP_5S = 8'h00, EXP_C = 8'h00;
`endif
  always #20 clk = ~clk;
  vdp_cpu_port_if #(.ADDR_W(14)) vif();
  vdp_cpu_port #(.ADDR_W(14), .NUM_REGS(8)) dut (
    .pxclk(clk), .reset_n(rst_n), .wr_tick(wr_tick), .rd_tick(rd_tick), .mode(mode),
    .din(din), .dout(dout), .irq(irq), .frame_tick(frame_tick), .coll_tick(coll_tick),
    .fifth_tick(fifth_tick), .fifth_num(fifth_num), .regs(regs), .ovr(ovr), .vram(vif)
  );
  always @(posedge clk or negedge rst_n)
    if (!rst_n) vif.ack <= 1'b0;
    else vif.ack <= vif.req && !vif.ack && !hold_ack;
  assign vif.rdata = vif.addr[7:0] ^ 8'h5A;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (vif.req && vif.ack) begin
      if (vq.size() == 0) begin
        checks++; failures++;
        $display("FAIL vram_unexpected: got we=%0d addr=0x%0h expected no access", vif.we, vif.addr);
      end else begin
        e = vq.pop_front();
        chk("vram_we", 64'(vif.we), 64'(e.we));
        chk("vram_addr", 64'(vif.addr), 64'(e.addr));
        if (e.we) chk("vram_wdata", 64'(vif.wdata), 64'(e.wdata));
      end
    end
    if (rd_tick && !wr_tick) begin
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL dout_unexpected: got 0x%0h expected no read", dout);
      end else chk("dout", 64'(dout), 64'(dq.pop_front()));
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic w, input logic r, input logic m, input logic [7:0] d,
                       input logic fr = 0, input logic co = 0, input logic fi = 0, input logic [4:0] fn = 0);
    @(posedge clk); #1;
    wr_tick = w; rd_tick = r; mode = m; din = d;
    frame_tick = fr; coll_tick = co; fifth_tick = fi; fifth_num = fn;
    @(posedge clk); #1;
    wr_tick = 0; rd_tick = 0; frame_tick = 0; coll_tick = 0; fifth_tick = 0;
  endtask
  task automatic ctl(input logic [7:0] d);
    drive(1, 0, 1, d);
  endtask
  task automatic dwr(input logic [13:0] a, input logic [7:0] d);
    vq.push_back({1'b1, a, d});
    drive(1, 0, 0, d);
    idle(4);
  endtask
  task automatic drd(input logic [13:0] a, input logic [7:0] exp);
    vq.push_back({1'b0, a, 8'h00});
    dq.push_back(exp);
    drive(0, 1, 0, 8'h00);
    idle(4);
  endtask
  task automatic srd(input logic [7:0] exp, input logic fr = 0);
    dq.push_back(exp);
    drive(0, 1, 1, 8'h00, fr);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    idle(3);
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_req", 64'(vif.req), 64'h0);
    chk("rst_ovr", 64'(ovr), 64'h0);
    chk("rst_regs", regs, 64'h0);
    rst_n = 1;
    idle(2);
    ctl(8'h34); ctl(8'h87); idle(3);
    chk("t1_reg7", 64'(regs[63:56]), 64'h34);
    chk("t1_others", 64'(regs[55:0]), 64'h0);
    ctl(8'h00); ctl(8'h40); idle(2);
    dwr(14'h0000, 8'hAA);
    dwr(14'h0001, 8'hBB);
    drd(14'h0002, 8'hBB);
    ctl(8'hFF);
    vq.push_back({1'b0, 14'h3FFF, 8'h00});
    ctl(8'h3F); idle(4);
    drd(14'h0000, 8'hA5);
    drd(14'h0001, 8'h5A);
    ctl(8'h20); ctl(8'h81); idle(1);
    chk("t4_reg1", 64'(regs[15:8]), 64'h20);
    chk("t4_irq_idle", 64'(irq), 64'h0);
    drive(0, 0, 0, 8'h00, 1);
    chk("t4_irq_set", 64'(irq), 64'h1);
    srd(8'h80);
    chk("t4_irq_clr", 64'(irq), 64'h0);
    drive(0, 0, 0, 8'h00, 1);
    srd(8'h80, 1);
    chk("t4_irq_setwins", 64'(irq), 64'h1);
    srd(8'h80);
    chk("t4_irq_clr2", 64'(irq), 64'h0);
    ctl(8'h00); ctl(8'h41); idle(2);
    chk("t5_ovr_before", 64'(ovr), 64'h0);
    hold_ack = 1;
    vq.push_back({1'b1, 14'h0100, 8'h11});
    drive(1, 0, 0, 8'h11); idle(1);
    drive(1, 0, 0, 8'h22);
    chk("t5_ovr", 64'(ovr), 64'h1);
    chk("t5_req_held", 64'(vif.req), 64'h1);
    hold_ack = 0; idle(4);
    dwr(14'h0101, 8'h33);
    vq.push_back({1'b1, 14'h0102, 8'h44});
    drive(1, 1, 0, 8'h44); idle(4);
    ctl(8'h55);
    dwr(14'h0103, 8'h66);
    ctl(8'h77); ctl(8'h82); idle(1);
    chk("t_mode_reg2", 64'(regs[23:16]), 64'h77);
    ctl(8'h5A); ctl(8'h8B); idle(1);
    chk("t_idx_reg3", 64'(regs[31:24]), 64'h5A);
    drive(0, 0, 0, 8'h00, 0, 0, 1, 5'h13);
    drive(0, 0, 0, 8'h00, 0, 0, 1, 5'h05);
    srd(EXP_5S);
    srd(8'h00);
    drive(0, 0, 0, 8'h00, 0, 1);
    srd(EXP_C);
    srd(8'h00);
    hold_ack = 1;
    drive(1, 0, 0, 8'h77);
    chk("rst_mid_req_before", 64'(vif.req), 64'h1);
    #5 rst_n = 0;
    #1 chk("rst_mid_req_drop", 64'(vif.req), 64'h0);
    hold_ack = 0;
    idle(2);
    rst_n = 1;
    idle(2);
    chk("rst_mid_regs", regs, 64'h0);
    chk("rst_mid_ovr", 64'(ovr), 64'h0);
    chk("vq_empty", 64'(vq.size()), 64'h0);
    chk("dq_empty", 64'(dq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
